// File: rtl/mdio_responder_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared constants and types for the Clause-22 MDIO responder.
// The frame layout is: preamble ones, ST (01), OP (2 bits), PHYAD (5 bits),
// REGAD (5 bits), TA (2 bits) and DATA (16 bits).
// -----------------------------------------------------------------------------
package mdio_pkg;

  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] ST_PATTERN = 2'b01;

  localparam int PHYAD_W   = 5;
  localparam int REGAD_W   = 5;
  localparam int DATA_W    = 16;
  localparam int BIT_CNT_W = 5;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // Last counter value of each counted phase.
  localparam bit_cnt_t OP_LAST    = 5'd1;
  localparam bit_cnt_t FIELD_LAST = 5'd4;
  localparam bit_cnt_t TA_LAST    = 5'd1;
  localparam bit_cnt_t WR_LAST    = 5'd15;
  localparam bit_cnt_t RD_LAST    = 5'd16;
  localparam bit_cnt_t SKIP_LAST  = 5'd17;

  typedef enum logic [2:0] {
    PREAMBLE = 3'd0,
    ST2      = 3'd1,
    OP       = 3'd2,
    PHYAD    = 3'd3,
    REGAD    = 3'd4,
    TA       = 3'd5,
    DATA     = 3'd6,
    SKIP     = 3'd7
  } mdio_state_t;

  // Only the two Clause-22 opcodes are accepted; 00 and 11 abandon the frame.
  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_responder_if.sv
// -----------------------------------------------------------------------------
// mdio_responder_if
// Groups the MDIO line signals and the local register-access bus.
//   mdc, mdio_i         : from the external station-management master
//   mdio_o, mdio_oe     : drive value / enable for the top-level tristate
//   reg_addr            : REGAD of the current frame
//   reg_rd_en           : one-cycle read strobe
//   reg_rd_data         : read data, valid one cycle after reg_rd_en
//   reg_wr_en           : one-cycle write strobe
//   reg_wr_data         : write data, held after the strobe
//   busy                : frame in progress (ST seen, not yet finished)
// slave  : the responder side.
// master : the environment side (MDIO master plus register file).
// -----------------------------------------------------------------------------
interface mdio_responder_if;

  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        busy;

  modport slave (
    input  mdc, mdio_i, reg_rd_data,
    output mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy
  );

  modport master (
    output mdc, mdio_i, reg_rd_data,
    input  mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, busy
  );

endinterface

// File: rtl/mdio_responder_mdc_edge_sync.sv
// -----------------------------------------------------------------------------
// mdc_edge_sync
// Brings MDC and MDIO into the local clock domain through two flip-flops each
// and produces a one-cycle pulse when the synchronised MDC goes 0->1.
//   i_clock, i_reset : local clock, synchronous active-high reset
//   i_mdc, i_mdio    : asynchronous MDC / MDIO line inputs
//   o_mdc_rise       : one-cycle MDC rising-edge pulse
//   o_mdio           : synchronised MDIO, aligned with o_mdc_rise
// -----------------------------------------------------------------------------
module mdc_edge_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_mdc,
  input  logic i_mdio,
  output logic o_mdc_rise,
  output logic o_mdio
);

  logic r_mdc_meta;
  logic r_mdc_sync;
  logic r_mdc_prev;
  logic r_mdio_meta;
  logic r_mdio_sync;

  // Two-stage synchronisers plus the delayed MDC copy for edge detection.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mdc_meta  <= 1'b0;
      r_mdc_sync  <= 1'b0;
      r_mdc_prev  <= 1'b0;
      r_mdio_meta <= 1'b1;  // idle line level (pull-up)
      r_mdio_sync <= 1'b1;
    end else begin
      r_mdc_meta  <= i_mdc;
      r_mdc_sync  <= r_mdc_meta;
      r_mdc_prev  <= r_mdc_sync;
      r_mdio_meta <= i_mdio;
      r_mdio_sync <= r_mdio_meta;
    end
  end

  // MDIO passes through the same depth as MDC, so the bit sampled on the
  // rise pulse is the one the master set up before raising MDC.
  assign o_mdc_rise = r_mdc_sync & ~r_mdc_prev;
  assign o_mdio     = r_mdio_sync;

endmodule

// File: rtl/mdio_responder.sv
// -----------------------------------------------------------------------------
// mdio_responder
// Clause-22 MDIO target. Oversamples MDC/MDIO, decodes read and write frames
// addressed to PHY_ADDR and turns them into single-cycle register strobes.
// Read data is shifted back on MDIO; the top level builds the tristate from
// mdio_o/mdio_oe.
//   clock  : local clock, at least 4x the MDC frequency
//   reset  : synchronous active-high reset
//   bus    : mdio_responder_if.slave (MDIO line + register access bus)
// Parameters:
//   PHY_ADDR      : PHY address answered by this responder
//   PREAMBLE_BITS : consecutive ones required before ST (0 = suppression)
// -----------------------------------------------------------------------------
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter int         PREAMBLE_BITS = 32
) (
  input  logic               clock,
  input  logic               reset,
  mdio_responder_if.slave    bus
);

  localparam int PRE_W = (PREAMBLE_BITS < 2) ? 1 : $clog2(PREAMBLE_BITS + 1);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PREAMBLE_BITS);
  localparam logic             PRE_NONE = (PREAMBLE_BITS == 0);

  logic w_mdc_rise;
  logic w_mdio;
  logic w_pre_done;

  // FSM state and counters
  mdio_state_t          r_state;
  mdio_state_t          w_state_nxt;
  logic [PRE_W-1:0]     r_pre_cnt;
  logic [PRE_W-1:0]     w_pre_cnt_nxt;
  bit_cnt_t             r_bit_cnt;
  bit_cnt_t             w_bit_cnt_nxt;

  // Frame datapath and registered outputs
  logic                 r_op_msb,   w_op_msb_nxt;
  logic                 r_is_read,  w_is_read_nxt;
  logic [PHYAD_W-1:0]   r_phyad,    w_phyad_nxt;
  logic [REGAD_W-1:0]   r_regad,    w_regad_nxt;
  logic [DATA_W-1:0]    r_shift,    w_shift_nxt;
  logic                 r_rd_latch, w_rd_latch_nxt;
  logic                 r_mdio_o,   w_mdio_o_nxt;
  logic                 r_mdio_oe,  w_mdio_oe_nxt;
  logic [REGAD_W-1:0]   r_reg_addr, w_reg_addr_nxt;
  logic                 r_rd_en,    w_rd_en_nxt;
  logic                 r_wr_en,    w_wr_en_nxt;
  logic [DATA_W-1:0]    r_wr_data,  w_wr_data_nxt;
  logic                 r_busy,     w_busy_nxt;

  mdc_edge_sync u_sync (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_mdc      (bus.mdc),
    .i_mdio     (bus.mdio_i),
    .o_mdc_rise (w_mdc_rise),
    .o_mdio     (w_mdio)
  );

  // With suppression enabled any 0 seen while idle is taken as ST.
  assign w_pre_done = PRE_NONE | (r_pre_cnt == PRE_MAX);

  // State register and bit/preamble counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= PREAMBLE;
      r_pre_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state logic; everything advances only on an MDC rising edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    if (w_mdc_rise) begin
      case (r_state)
        PREAMBLE: begin
          if (w_mdio == ST_PATTERN[1]) begin
            // A 0 either starts ST or breaks an incomplete preamble.
            w_pre_cnt_nxt = '0;
            if (w_pre_done) begin
              w_state_nxt = ST2;
            end else begin
              w_state_nxt = PREAMBLE;
            end
          end else if (!w_pre_done) begin
            w_pre_cnt_nxt = r_pre_cnt + PRE_W'(1);
          end else begin
            w_pre_cnt_nxt = r_pre_cnt;
          end
        end
        ST2: begin
          w_bit_cnt_nxt = '0;
          if (w_mdio == ST_PATTERN[0]) begin
            w_state_nxt = OP;
          end else begin
            w_state_nxt = PREAMBLE;
          end
        end
        OP: begin
          if (r_bit_cnt != OP_LAST) begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end else begin
            w_bit_cnt_nxt = '0;
            if (op_valid({r_op_msb, w_mdio})) begin
              w_state_nxt = PHYAD;
            end else begin
              w_state_nxt = PREAMBLE;
            end
          end
        end
        PHYAD: begin
          if (r_bit_cnt == FIELD_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = REGAD;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        REGAD: begin
          if (r_bit_cnt == FIELD_LAST) begin
            w_bit_cnt_nxt = '0;
            if (r_phyad == PHY_ADDR) begin
              w_state_nxt = TA;
            end else begin
              w_state_nxt = SKIP;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        TA: begin
          // A read leaves TA after the first bit: the responder owns the
          // second TA bit and drives it from the DATA phase timing.
          if (r_is_read || (r_bit_cnt == TA_LAST)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = DATA;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        DATA: begin
          if ((r_is_read && (r_bit_cnt == RD_LAST)) ||
              (!r_is_read && (r_bit_cnt == WR_LAST))) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = PREAMBLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        SKIP: begin
          if (r_bit_cnt == SKIP_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = PREAMBLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        default: begin
          w_state_nxt   = PREAMBLE;
          w_pre_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
        end
      endcase
    end else begin
      w_state_nxt   = r_state;
      w_pre_cnt_nxt = r_pre_cnt;
      w_bit_cnt_nxt = r_bit_cnt;
    end
  end

  // Output/datapath next values: strobes, shift register and MDIO drive.
  always_comb begin
    w_op_msb_nxt   = r_op_msb;
    w_is_read_nxt  = r_is_read;
    w_phyad_nxt    = r_phyad;
    w_regad_nxt    = r_regad;
    w_shift_nxt    = r_shift;
    w_mdio_o_nxt   = r_mdio_o;
    w_mdio_oe_nxt  = r_mdio_oe;
    w_reg_addr_nxt = r_reg_addr;
    w_wr_data_nxt  = r_wr_data;
    w_busy_nxt     = r_busy;
    w_rd_en_nxt    = 1'b0;
    w_wr_en_nxt    = 1'b0;
    // Read data is valid the cycle after the strobe; capture it then.
    w_rd_latch_nxt = r_rd_en;
    if (r_rd_latch) begin
      w_shift_nxt = bus.reg_rd_data;
    end else begin
      w_shift_nxt = r_shift;
    end
    if (w_mdc_rise) begin
      case (r_state)
        PREAMBLE: begin
          w_busy_nxt = 1'b0;
        end
        ST2: begin
          if (w_mdio == ST_PATTERN[0]) begin
            w_busy_nxt = 1'b1;
          end else begin
            w_busy_nxt = 1'b0;
          end
        end
        OP: begin
          w_op_msb_nxt = w_mdio;
          if (r_bit_cnt == OP_LAST) begin
            w_is_read_nxt = ({r_op_msb, w_mdio} == OP_READ);
            if (op_valid({r_op_msb, w_mdio})) begin
              w_busy_nxt = 1'b1;
            end else begin
              w_busy_nxt = 1'b0;
            end
          end else begin
            w_is_read_nxt = r_is_read;
          end
        end
        PHYAD: begin
          w_phyad_nxt = {r_phyad[PHYAD_W-2:0], w_mdio};
        end
        REGAD: begin
          w_regad_nxt = {r_regad[REGAD_W-2:0], w_mdio};
          if (r_bit_cnt == FIELD_LAST) begin
            w_reg_addr_nxt = {r_regad[REGAD_W-2:0], w_mdio};
            if ((r_phyad == PHY_ADDR) && r_is_read) begin
              w_rd_en_nxt = 1'b1;
            end else begin
              w_rd_en_nxt = 1'b0;
            end
          end else begin
            w_reg_addr_nxt = r_reg_addr;
          end
        end
        TA: begin
          // Master has released the line after TA1; drive the TA2 zero.
          if (r_is_read) begin
            w_mdio_oe_nxt = 1'b1;
            w_mdio_o_nxt  = 1'b0;
          end else begin
            w_mdio_oe_nxt = 1'b0;
          end
        end
        DATA: begin
          if (r_is_read) begin
            if (r_bit_cnt == RD_LAST) begin
              w_mdio_oe_nxt = 1'b0;
              w_mdio_o_nxt  = 1'b0;
              w_busy_nxt    = 1'b0;
            end else begin
              w_mdio_o_nxt = r_shift[DATA_W-1];
              w_shift_nxt  = {r_shift[DATA_W-2:0], 1'b0};
            end
          end else begin
            w_shift_nxt = {r_shift[DATA_W-2:0], w_mdio};
            if (r_bit_cnt == WR_LAST) begin
              w_wr_data_nxt = {r_shift[DATA_W-2:0], w_mdio};
              w_wr_en_nxt   = 1'b1;
              w_busy_nxt    = 1'b0;
            end else begin
              w_wr_en_nxt = 1'b0;
            end
          end
        end
        SKIP: begin
          if (r_bit_cnt == SKIP_LAST) begin
            w_busy_nxt = 1'b0;
          end else begin
            w_busy_nxt = r_busy;
          end
        end
        default: begin
          w_mdio_oe_nxt = 1'b0;
          w_mdio_o_nxt  = 1'b0;
          w_busy_nxt    = 1'b0;
        end
      endcase
    end else begin
      w_busy_nxt = r_busy;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_msb   <= 1'b0;
      r_is_read  <= 1'b0;
      r_phyad    <= '0;
      r_regad    <= '0;
      r_shift    <= '0;
      r_rd_latch <= 1'b0;
      r_mdio_o   <= 1'b0;
      r_mdio_oe  <= 1'b0;
      r_reg_addr <= '0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_op_msb   <= w_op_msb_nxt;
      r_is_read  <= w_is_read_nxt;
      r_phyad    <= w_phyad_nxt;
      r_regad    <= w_regad_nxt;
      r_shift    <= w_shift_nxt;
      r_rd_latch <= w_rd_latch_nxt;
      r_mdio_o   <= w_mdio_o_nxt;
      r_mdio_oe  <= w_mdio_oe_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign bus.mdio_o      = r_mdio_o;
  assign bus.mdio_oe     = r_mdio_oe;
  assign bus.reg_addr    = r_reg_addr;
  assign bus.reg_rd_en   = r_rd_en;
  assign bus.reg_wr_en   = r_wr_en;
  assign bus.reg_wr_data = r_wr_data;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_mdio_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_responder
// Directed bench: an MDIO master model drives frames bit by bit (MDC period of
// 8 local clocks) into two responders, one with a 32-bit preamble and one with
// preamble suppression. A tiny register model returns 16'hA5C3 only in the
// cycle after reg_rd_en.
// -----------------------------------------------------------------------------
module tb_mdio_responder;
  import mdio_pkg::*;

  localparam logic [15:0] RD_WORD = 16'hA5C3;

  logic clock = 1'b0;
  logic rst;
  logic m_mdc_a;
  logic m_mdc_b;
  logic m_mdio;

  int checks = 0;
  int errors = 0;

  int rd_cnt_a  = 0;
  int wr_cnt_a  = 0;
  int oe_cyc_a  = 0;
  int wr_cnt_b  = 0;
  logic [15:0] wr_log_b [0:3];
  logic [15:0] rd_q_a;

  always #5 clock = ~clock;

  mdio_responder_if if_a ();
  mdio_responder_if if_b ();

  // Master releases the line (pull-up) whenever the responder drives it.
  assign if_a.mdc         = m_mdc_a;
  assign if_a.mdio_i      = if_a.mdio_oe ? if_a.mdio_o : m_mdio;
  assign if_a.reg_rd_data = rd_q_a;
  assign if_b.mdc         = m_mdc_b;
  assign if_b.mdio_i      = if_b.mdio_oe ? if_b.mdio_o : m_mdio;
  assign if_b.reg_rd_data = 16'h0000;

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_BITS(32)) u_dut_a (
    .clock (clock),
    .reset (rst),
    .bus   (if_a.slave)
  );

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_BITS(0)) u_dut_b (
    .clock (clock),
    .reset (rst),
    .bus   (if_b.slave)
  );

  // Register model and strobe bookkeeping.
  always @(posedge clock) begin
    rd_q_a <= if_a.reg_rd_en ? RD_WORD : 16'hDEAD;
    if (if_a.reg_rd_en) rd_cnt_a <= rd_cnt_a + 1;
    if (if_a.reg_wr_en) wr_cnt_a <= wr_cnt_a + 1;
    if (if_a.mdio_oe)   oe_cyc_a <= oe_cyc_a + 1;
    if (if_b.reg_wr_en) begin
      wr_log_b[wr_cnt_b[1:0]] <= if_b.reg_wr_data;
      wr_cnt_b <= wr_cnt_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One MDC period; returns the line value and oe seen just before the rise.
  task automatic clk_bit(input logic sel, input logic b, output logic line, output logic oe);
    m_mdio = b;
    repeat (4) @(posedge clock);
    #1;
    if (sel) begin
      line = if_b.mdio_i;
      oe = if_b.mdio_oe;
      m_mdc_b = 1'b1;
    end else begin
      line = if_a.mdio_i;
      oe = if_a.mdio_oe;
      m_mdc_a = 1'b1;
    end
    repeat (4) @(posedge clock);
    #1;
    m_mdc_a = 1'b0;
    m_mdc_b = 1'b0;
  endtask

  task automatic send_bits(input logic sel, input logic [31:0] v, input int n);
    logic l, o;
    for (int i = n - 1; i >= 0; i--) clk_bit(sel, v[i], l, o);
  endtask

  task automatic send_pre(input logic sel, input int n);
    logic l, o;
    for (int i = 0; i < n; i++) clk_bit(sel, 1'b1, l, o);
  endtask

  task automatic send_hdr(input logic sel, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] rg);
    send_bits(sel, {18'd0, 2'b01, op, phy, rg}, 14);
  endtask

  task automatic send_write(input logic sel, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] d);
    send_hdr(sel, OP_WRITE, phy, rg);
    send_bits(sel, {14'd0, 2'b10, d}, 18);
  endtask

  task automatic read_tail(input logic sel, output logic [17:0] line_v, output logic [17:0] oe_v);
    logic l, o;
    for (int i = 17; i >= 0; i--) begin
      clk_bit(sel, 1'b1, l, o);
      line_v[i] = l;
      oe_v[i] = o;
    end
  endtask

  initial begin
    logic [17:0] line_v;
    logic [17:0] oe_v;
    logic l, o;
    int rd_base;
    int oe_base;

    rst = 1'b1;
    m_mdc_a = 1'b0;
    m_mdc_b = 1'b0;
    m_mdio = 1'b1;
    idle(3);

    // Reset state
    check("rst_oe",      32'(if_a.mdio_oe),     32'd0);
    check("rst_o",       32'(if_a.mdio_o),      32'd0);
    check("rst_rd_en",   32'(if_a.reg_rd_en),   32'd0);
    check("rst_wr_en",   32'(if_a.reg_wr_en),   32'd0);
    check("rst_addr",    32'(if_a.reg_addr),    32'd0);
    check("rst_wdata",   32'(if_a.reg_wr_data), 32'd0);
    check("rst_busy",    32'(if_a.busy),        32'd0);
    check("rst_state",   32'(u_dut_a.r_state),  32'(PREAMBLE));
    rst = 1'b0;
    idle(2);

    // Matching read: REGAD 5, expect TA Z/0 then A5C3 MSB first
    send_pre(1'b0, 32);
    send_hdr(1'b0, OP_READ, 5'd1, 5'd5);
    idle(2);
    check("rd_busy",     32'(if_a.busy),     32'd1);
    check("rd_strobe",   32'(rd_cnt_a),      32'd1);
    check("rd_addr",     32'(if_a.reg_addr), 32'd5);
    read_tail(1'b0, line_v, oe_v);
    idle(2);
    check("rd_oe_win",   32'(oe_v),          32'h1FFFF);
    check("rd_line",     32'(line_v),        32'h2A5C3);
    check("rd_oe_end",   32'(if_a.mdio_oe),  32'd0);
    check("rd_busy_end", 32'(if_a.busy),     32'd0);
    check("rd_once",     32'(rd_cnt_a),      32'd1);

    // Matching write: REGAD 11, data 1300, never drives
    oe_base = oe_cyc_a;
    send_pre(1'b0, 32);
    send_write(1'b0, 5'd1, 5'd11, 16'h1300);
    idle(2);
    check("wr_strobe",   32'(wr_cnt_a),         32'd1);
    check("wr_addr",     32'(if_a.reg_addr),    32'd11);
    check("wr_data",     32'(if_a.reg_wr_data), 32'h1300);
    check("wr_no_oe",    32'(oe_cyc_a),         32'(oe_base));
    check("wr_busy_end", 32'(if_a.busy),        32'd0);

    // Address mismatch: read to PHYAD 3 is skipped
    rd_base = rd_cnt_a;
    oe_base = oe_cyc_a;
    send_pre(1'b0, 32);
    send_hdr(1'b0, OP_READ, 5'd3, 5'd5);
    read_tail(1'b0, line_v, oe_v);
    idle(2);
    check("mis_no_rd",   32'(rd_cnt_a),  32'(rd_base));
    check("mis_no_oe",   32'(oe_cyc_a),  32'(oe_base));
    check("mis_busy",    32'(if_a.busy), 32'd0);
    send_pre(1'b0, 32);
    send_write(1'b0, 5'd1, 5'd2, 16'hBEEF);
    idle(2);
    check("mis_wr_cnt",  32'(wr_cnt_a),         32'd2);
    check("mis_wr_data", 32'(if_a.reg_wr_data), 32'hBEEF);
    check("mis_wr_addr", 32'(if_a.reg_addr),    32'd2);

    // Short preamble: 31 ones, read is ignored
    send_pre(1'b0, 31);
    send_hdr(1'b0, OP_READ, 5'd1, 5'd5);
    read_tail(1'b0, line_v, oe_v);
    idle(2);
    check("short_no_rd", 32'(rd_cnt_a),  32'(rd_base));
    check("short_no_oe", 32'(oe_cyc_a),  32'(oe_base));
    check("short_busy",  32'(if_a.busy), 32'd0);

    // Bad opcode 11: busy after ST, cleared after OP, no strobes
    send_pre(1'b0, 32);
    send_bits(1'b0, 32'h1, 2);
    idle(2);
    check("badop_busy",  32'(if_a.busy), 32'd1);
    send_bits(1'b0, 32'h3, 2);
    idle(2);
    check("badop_clear", 32'(if_a.busy), 32'd0);
    send_pre(1'b0, 12);
    check("badop_no_rd", 32'(rd_cnt_a),  32'(rd_base));
    check("badop_no_wr", 32'(wr_cnt_a),  32'd2);

    // Reset in the middle of read data
    send_pre(1'b0, 32);
    send_hdr(1'b0, OP_READ, 5'd1, 5'd7);
    for (int i = 0; i < 9; i++) clk_bit(1'b0, 1'b1, l, o);
    check("mid_oe_on",   32'(if_a.mdio_oe), 32'd1);
    rst = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_oe",  32'(if_a.mdio_oe),    32'd0);
    check("mid_rst_st",  32'(u_dut_a.r_state), 32'(PREAMBLE));
    check("mid_rst_bsy", 32'(if_a.busy),       32'd0);
    rst = 1'b0;
    idle(2);
    send_pre(1'b0, 32);
    send_hdr(1'b0, OP_READ, 5'd1, 5'd9);
    read_tail(1'b0, line_v, oe_v);
    idle(2);
    check("post_rst_line", 32'(line_v),        32'h2A5C3);
    check("post_rst_addr", 32'(if_a.reg_addr), 32'd9);
    check("post_rst_oe",   32'(if_a.mdio_oe),  32'd0);

    // Preamble suppression: two back-to-back writes
    send_write(1'b1, 5'd1, 5'd3, 16'h1234);
    send_write(1'b1, 5'd1, 5'd4, 16'hC0DE);
    idle(3);
    check("ps_wr_cnt",   32'(wr_cnt_b),     32'd2);
    check("ps_data0",    32'(wr_log_b[0]),  32'h1234);
    check("ps_data1",    32'(wr_log_b[1]),  32'hC0DE);
    check("ps_addr",     32'(if_b.reg_addr), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- Clause-22 MDIO target (responder) for the management bus.
- Lets the FPGA present a PHY-style register set to an external MDIO master (station management).
- Also serves as the bench counterpart for the PHY-configuration master.
- Oversamples MDC/MDIO in the local clock domain, decodes read/write frames addressed to its PHY address, and drives read data back on the shared MDIO line through a top-level tristate.

Parameters:
- PHY_ADDR, 5'd1: PHY address this responder answers to.
- PREAMBLE_BITS, 32: consecutive ones required before ST. 0 means preamble suppression is accepted.

Ports:
- clock  input  1  system clock; must be >= 4x MDC frequency.
- reset  input  1  synchronous, active-high reset.
- mdc  input  1  MDC from the master; asynchronous to clock.
- mdio_i  input  1  MDIO line input.
- mdio_o  output  1  MDIO drive value.
- mdio_oe  output  1  MDIO output enable; the top level builds the tristate.
- reg_addr  output  5  REGAD of the current frame; held until the next frame's REGAD.
- reg_rd_en  output  1  one-cycle read strobe.
- reg_rd_data  input  16  register read data; sampled exactly 1 cycle after reg_rd_en.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_wr_data  output  16  write data; valid while reg_wr_en is high and held afterwards.
- busy  output  1  high from ST detection until the frame ends or is abandoned.

Behaviour:
- Reset values: mdio_oe=0, mdio_o=0, reg_rd_en=0, reg_wr_en=0, reg_addr=0, reg_wr_data=0, busy=0, state=PREAMBLE, preamble counter=0. Reset during a read releases the bus at the next edge.
- Input sync: mdc and mdio_i each pass through 2 flip-flops. An MDC rising event (mdc_rise) is a one-cycle pulse when the synced MDC goes 0->1. All bit sampling happens on mdc_rise using synced MDIO. All drive changes happen on the cycle after mdc_rise.
- PREAMBLE state:
  - Counts consecutive sampled ones, saturating at PREAMBLE_BITS.
  - A sampled 0 when count >= PREAMBLE_BITS goes to ST2; otherwise the count clears.
- ST2: expects 1. On 1, busy=1 and go to OP; on 0, return to PREAMBLE with count 0.
- OP: 2 bits. 10 = read, 01 = write. 00 or 11 returns to PREAMBLE with busy=0.
- PHYAD: 5 bits, MSB first.
- REGAD: 5 bits, MSB first.
  - After the last REGAD bit, load reg_addr.
  - If PHYAD != PHY_ADDR, go to SKIP (count 18 bits, no drive, no strobes), then PREAMBLE.
- Read path (R = mdc_rise that sampled REGAD[0]):
  - Cycle after R: pulse reg_rd_en. Next cycle: latch reg_rd_data into the shift register.
  - After R+1 (first TA bit, master released): mdio_oe=1, mdio_o=0.
  - After R+2: drive data[15]. After R+2+k: drive data[15-k], through data[0] after R+17.
  - After R+18: mdio_oe=0, busy=0, go to PREAMBLE.
- Write path:
  - TA: 2 bits sampled and ignored.
  - DATA: 16 bits, MSB first, shifted in.
  - On the cycle after the 16th data mdc_rise: reg_wr_data=word, reg_wr_en=1 for one cycle, busy=0, go to PREAMBLE.
- Preamble counting restarts from 0 after every frame. Back-to-back frames therefore need a fresh preamble, unless PREAMBLE_BITS=0.
- mdio_oe is never asserted outside the read TA2/DATA window. mdio_i is ignored while mdio_oe=1.
- MDC stopping mid-frame: state holds indefinitely; there is no timeout.

Decomposition:
- Package mdio_pkg:
  - OP_READ=2'b10, OP_WRITE=2'b01.
  - ST pattern 2'b01.
  - Field widths (PHYAD 5, REGAD 5, DATA 16).
  - State enum {PREAMBLE, ST2, OP, PHYAD, REGAD, TA, DATA, SKIP}.
  - TA/data bit counter width.
- Sub-module mdc_edge_sync: 2-FF synchronizers for mdc/mdio_i plus the mdc_rise pulse generator.

Test Plan:
- Read, matching address: PHY_ADDR=1, 32 ones + 01 10 00001 00101 + Z Z, reg_rd_data=16'hA5C3 -> one reg_rd_en with reg_addr=5; mdio_oe rises after TA1; master samples 0 then A5C3 MSB-first; oe drops after the 18th read bit.
- Write, matching address: 32 ones + 01 01 00001 01011 10 + 16'h1300 -> exactly one reg_wr_en, reg_addr=11, reg_wr_data=16'h1300; mdio_oe never asserted.
- Address mismatch: read frame to PHYAD 3 -> no reg_rd_en, mdio_oe stays 0. A following valid write to PHYAD 1 (fresh preamble) is accepted.
- Short preamble / bad opcode: 31 ones + valid read -> ignored. 32 ones + OP 11 -> busy pulses then clears, with no strobes.
- Reset mid-read at data bit 7 -> mdio_oe=0 the next cycle and state=PREAMBLE. The next full read frame returns correct data.
- PREAMBLE_BITS=0: two back-to-back write frames with no preamble -> two reg_wr_en pulses with the correct data.
